// File: rtl/mem_dp_be.sv
// mem_dp_be: simple dual-port synchronous RAM with per-byte write enables,
// read-valid strobe, selectable same-address collision mode, read range
// checking and a hardware clear sequencer that zeroes the array after reset
// or on an init_start request.
// Optional macro MEM_DP_BE_OUT_REG_EN adds one output register stage
// (read latency 2, rd_valid/addr_err delayed to stay aligned with dout).
module mem_dp_be #(
  parameter int MEM_WIDTH = 16,
  parameter int MEM_DEPTH = 1024,
  parameter int ADD_SIZE  = 10,
  parameter int BYTE_W    = 8,
  parameter int RD_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          blk_select,
  input  logic                          wr_en,
  input  logic [MEM_WIDTH/BYTE_W-1:0]   wr_be,
  input  logic [ADD_SIZE-1:0]           addr_wr,
  input  logic [MEM_WIDTH-1:0]          din,
  input  logic                          rd_en,
  input  logic [ADD_SIZE-1:0]           addr_rd,
  input  logic                          init_start,
  output logic [MEM_WIDTH-1:0]          dout,
  output logic                          rd_valid,
  output logic                          addr_err,
  output logic                          init_busy
);

  localparam int NUM_BE = MEM_WIDTH / BYTE_W;
  // One extra bit so a depth of exactly 2**ADD_SIZE still compares correctly.
  localparam logic [ADD_SIZE:0]   DEPTH_EXT = (ADD_SIZE + 1)'(MEM_DEPTH);
  localparam logic [ADD_SIZE-1:0] LAST_ADDR = ADD_SIZE'(MEM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Lane-wise merge: lanes with be set take new data, the rest keep old data.
  function automatic logic [MEM_WIDTH-1:0] merge_lanes(
    input logic [MEM_WIDTH-1:0] old_word,
    input logic [MEM_WIDTH-1:0] new_word,
    input logic [NUM_BE-1:0]    be
  );
    logic [MEM_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NUM_BE; i++) begin
      if (be[i]) begin
        res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end else begin
        res[i*BYTE_W +: BYTE_W] = old_word[i*BYTE_W +: BYTE_W];
      end
    end
    return res;
  endfunction

  state_e                state_r;
  logic [ADD_SIZE-1:0]   init_cnt_r;
  logic                  init_busy_r;
  logic [MEM_WIDTH-1:0]  mem_r [MEM_DEPTH];

  logic                  idle_s;
  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  wr_fire_s;
  logic                  rd_fire_s;
  logic                  collide_s;
  logic [MEM_WIDTH-1:0]  old_wr_word_s;
  logic [MEM_WIDTH-1:0]  new_wr_word_s;
  logic [MEM_WIDTH-1:0]  rd_word_s;
  logic [MEM_WIDTH-1:0]  rd_data_s;

  logic [MEM_WIDTH-1:0]  dout_r;
  logic                  rd_valid_r;
  logic                  addr_err_r;

  // Port qualification, write merge and collision-aware read data selection
  always_comb begin
    idle_s        = (state_r == ST_IDLE);
    wr_in_range_s = ({1'b0, addr_wr} < DEPTH_EXT);
    rd_in_range_s = ({1'b0, addr_rd} < DEPTH_EXT);
    wr_fire_s     = idle_s & blk_select & wr_en & wr_in_range_s;
    rd_fire_s     = idle_s & blk_select & rd_en;
    collide_s     = wr_fire_s & rd_in_range_s & (addr_wr == addr_rd);
    old_wr_word_s = mem_r[addr_wr];
    new_wr_word_s = merge_lanes(old_wr_word_s, din, wr_be);
    rd_word_s     = mem_r[addr_rd];
    if (!rd_in_range_s) begin
      rd_data_s = '0;
    end else if (collide_s && (RD_MODE == 1)) begin
      rd_data_s = new_wr_word_s;
    end else begin
      rd_data_s = rd_word_s;
    end
  end

  // Array write port: the INIT sweep zeroes one word per cycle, IDLE takes user writes
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[init_cnt_r] <= '0;
    end else if (wr_fire_s) begin
      mem_r[addr_wr] <= new_wr_word_s;
    end
  end

  // Clear sequencer FSM: sweep every address after reset or on init_start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= '0;
      init_busy_r <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (init_cnt_r == LAST_ADDR) begin
            state_r     <= ST_IDLE;
            init_cnt_r  <= '0;
            init_busy_r <= 1'b0;
          end else begin
            init_cnt_r  <= init_cnt_r + ADD_SIZE'(1);
          end
        end
        ST_IDLE: begin
          if (init_start) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= '0;
            init_busy_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_INIT;
          init_cnt_r  <= '0;
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end

  // First read stage: dout holds between reads, strobes pulse for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_r     <= '0;
      rd_valid_r <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_fire_s;
      addr_err_r <= rd_fire_s & ~rd_in_range_s;
      if (rd_fire_s) begin
        dout_r <= rd_data_s;
      end
    end
  end

`ifdef MEM_DP_BE_OUT_REG_EN
  logic [MEM_WIDTH-1:0]  dout_q_r;
  logic                  rd_valid_q_r;
  logic                  addr_err_q_r;

  // Second read stage: retimes data and strobes together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q_r     <= '0;
      rd_valid_q_r <= 1'b0;
      addr_err_q_r <= 1'b0;
    end else begin
      dout_q_r     <= dout_r;
      rd_valid_q_r <= rd_valid_r;
      addr_err_q_r <= addr_err_r;
    end
  end

  assign dout     = dout_q_r;
  assign rd_valid = rd_valid_q_r;
  assign addr_err = addr_err_q_r;
`else
  assign dout     = dout_r;
  assign rd_valid = rd_valid_r;
  assign addr_err = addr_err_r;
`endif

  assign init_busy = init_busy_r;

endmodule

// File: tb/tb_mem_dp_be.sv
// tb_mem_dp_be: scoreboard bench for mem_dp_be. Two instances share stimulus:
// u_dut_a uses default parameters (read-first), u_dut_b uses MEM_DEPTH=1000
// with write-first collision mode. A behavioural model per instance pushes
// expected read results on issue; they are popped when due and compared.
module tb_mem_dp_be;

`ifdef MEM_DP_BE_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        err;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        blk_select;
  logic        wr_en;
  logic [1:0]  wr_be;
  logic [9:0]  addr_wr;
  logic [15:0] din;
  logic        rd_en;
  logic [9:0]  addr_rd;
  logic        init_start;
  logic [15:0] dout_a, dout_b;
  logic        rd_valid_a, rd_valid_b;
  logic        addr_err_a, addr_err_b;
  logic        init_busy_a, init_busy_b;

  int          n_checks;
  int          n_fail;
  int          cyc;
  sb_t         q_a[$];
  sb_t         q_b[$];
  logic [15:0] mem_m [2][1024];
  logic        busy_m [2];
  int          cnt_m [2];
  logic [15:0] last_dout_m [2];

  mem_dp_be u_dut_a (
    .clk(clk), .rst(rst), .blk_select(blk_select), .wr_en(wr_en), .wr_be(wr_be),
    .addr_wr(addr_wr), .din(din), .rd_en(rd_en), .addr_rd(addr_rd),
    .init_start(init_start), .dout(dout_a), .rd_valid(rd_valid_a),
    .addr_err(addr_err_a), .init_busy(init_busy_a)
  );

  mem_dp_be #(.MEM_WIDTH(16), .MEM_DEPTH(1000), .ADD_SIZE(10), .BYTE_W(8), .RD_MODE(1)) u_dut_b (
    .clk(clk), .rst(rst), .blk_select(blk_select), .wr_en(wr_en), .wr_be(wr_be),
    .addr_wr(addr_wr), .din(din), .rd_en(rd_en), .addr_rd(addr_rd),
    .init_start(init_start), .dout(dout_b), .rd_valid(rd_valid_b),
    .addr_err(addr_err_b), .init_busy(init_busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic blk, input logic we, input logic [1:0] be,
                       input logic [9:0] aw, input logic [15:0] d,
                       input logic re, input logic [9:0] ar, input logic is);
    blk_select = blk; wr_en = we; wr_be = be; addr_wr = aw; din = d;
    rd_en = re; addr_rd = ar; init_start = is;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b0, 10'd0, 1'b0);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy_m[d] = 1'b1;
      cnt_m[d] = 0;
      last_dout_m[d] = 16'h0000;
    end
    q_a.delete();
    q_b.delete();
  endtask

  // Expected behaviour of one instance at a rising edge, from pre-edge inputs.
  task automatic model_edge(input int d);
    int depth;
    logic [15:0] old_w, new_w;
    logic wfire;
    sb_t e;
    depth = (d == 0) ? 1024 : 1000;
    if (busy_m[d]) begin
      mem_m[d][cnt_m[d]] = 16'h0000;
      if (cnt_m[d] == depth - 1) begin
        busy_m[d] = 1'b0;
        cnt_m[d] = 0;
      end else begin
        cnt_m[d]++;
      end
    end else begin
      wfire = blk_select && wr_en && (int'(addr_wr) < depth);
      old_w = mem_m[d][addr_wr];
      new_w = {wr_be[1] ? din[15:8] : old_w[15:8], wr_be[0] ? din[7:0] : old_w[7:0]};
      if (blk_select && rd_en) begin
        e.due = cyc + LAT;
        if (int'(addr_rd) >= depth) begin
          e.data = 16'h0000;
          e.err = 1'b1;
        end else begin
          e.err = 1'b0;
          if (d == 1 && wfire && addr_wr == addr_rd) e.data = new_w;
          else e.data = mem_m[d][addr_rd];
        end
        if (d == 0) q_a.push_back(e);
        else q_b.push_back(e);
      end
      if (wfire) mem_m[d][addr_wr] = new_w;
      if (init_start) begin
        busy_m[d] = 1'b1;
        cnt_m[d] = 0;
      end
    end
  endtask

  task automatic compare_dut(input int d);
    sb_t e;
    bit have;
    logic v, er, bz;
    logic [15:0] dq;
    have = 1'b0;
    if (d == 0) begin
      v = rd_valid_a; er = addr_err_a; bz = init_busy_a; dq = dout_a;
      if (q_a.size() != 0 && q_a[0].due == cyc) begin e = q_a.pop_front(); have = 1'b1; end
    end else begin
      v = rd_valid_b; er = addr_err_b; bz = init_busy_b; dq = dout_b;
      if (q_b.size() != 0 && q_b[0].due == cyc) begin e = q_b.pop_front(); have = 1'b1; end
    end
    check_val($sformatf("init_busy_%0d@%0d", d, cyc), 32'(bz), 32'(busy_m[d]));
    if (have) begin
      check_val($sformatf("rd_valid_%0d@%0d", d, cyc), 32'(v), 32'd1);
      check_val($sformatf("addr_err_%0d@%0d", d, cyc), 32'(er), 32'(e.err));
      check_val($sformatf("dout_%0d@%0d", d, cyc), 32'(dq), 32'(e.data));
      last_dout_m[d] = e.data;
    end else begin
      check_val($sformatf("no_valid_%0d@%0d", d, cyc), 32'(v), 32'd0);
      check_val($sformatf("no_err_%0d@%0d", d, cyc), 32'(er), 32'd0);
      check_val($sformatf("dout_hold_%0d@%0d", d, cyc), 32'(dq), 32'(last_dout_m[d]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_edge(0);
      model_edge(1);
    end
    cyc++;
    #1;
    compare_dut(0);
    compare_dut(1);
  endtask

  task automatic op_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
    drive(1'b1, 1'b1, be, a, d, 1'b0, 10'd0, 1'b0);
    tick();
    idle();
  endtask

  // Issues one read and returns once its result is visible on dout.
  task automatic op_read(input logic [9:0] a);
    drive(1'b1, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b1, a, 1'b0);
    tick();
    idle();
    for (int k = 1; k < LAT; k++) tick();
  endtask

  task automatic drain();
    for (int k = 0; k < LAT + 1; k++) tick();
  endtask

  // Counts cycles each instance spends busy; optional noise ops in the first 500.
  task automatic run_init(input bit noisy, output int n_a, output int n_b);
    n_a = 0;
    n_b = 0;
    for (int i = 0; i < 3000 && (init_busy_a || init_busy_b); i++) begin
      if (noisy && i < 500) drive(1'b1, 1'b1, 2'b11, 10'(i % 4), 16'hFFFF, 1'b1, 10'(i % 4), 1'b1);
      else idle();
      if (init_busy_a) n_a++;
      if (init_busy_b) n_b++;
      tick();
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_a, n_b, n;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    rst = 1'b0;
    idle();
    model_reset();
    tick();
    tick();
    check_val("rst_busy_a", 32'(init_busy_a), 32'd1);
    check_val("rst_dout_a", 32'(dout_a), 32'd0);

    // Clear after reset
    rst = 1'b1;
    run_init(1'b0, n_a, n_b);
    check_val("init_len_a", 32'(n_a), 32'd1024);
    check_val("init_len_b", 32'(n_b), 32'd1000);
    op_read(10'd0);
    check_val("clr0_a", 32'(dout_a), 32'h0000);
    check_val("clr0_valid_a", 32'(rd_valid_a), 32'd1);
    op_read(10'd511);
    check_val("clr511_a", 32'(dout_a), 32'h0000);
    op_read(10'd1023);
    check_val("clr1023_a", 32'(dout_a), 32'h0000);
    check_val("clr1023_err_a", 32'(addr_err_a), 32'd0);
    check_val("rng1023_err_b", 32'(addr_err_b), 32'd1);

    // Byte-lane write
    op_write(10'd5, 16'hA1B2, 2'b11);
    op_write(10'd5, 16'hFFFF, 2'b01);
    op_write(10'd5, 16'h0000, 2'b00);
    op_read(10'd5);
    check_val("be_merge_a", 32'(dout_a), 32'hA1FF);
    check_val("be_merge_b", 32'(dout_b), 32'hA1FF);

    // Collision on addr 7
    drive(1'b1, 1'b1, 2'b11, 10'd7, 16'h1234, 1'b1, 10'd7, 1'b0);
    tick();
    idle();
    for (int k = 1; k < LAT; k++) tick();
    check_val("coll_rfirst_a", 32'(dout_a), 32'h0000);
    check_val("coll_wfirst_b", 32'(dout_b), 32'h1234);
    op_read(10'd7);
    check_val("coll_after_a", 32'(dout_a), 32'h1234);
    check_val("coll_after_b", 32'(dout_b), 32'h1234);

    // Range: out-of-range read and dropped write on the 1000-deep instance
    op_read(10'd1010);
    check_val("rng_dout_b", 32'(dout_b), 32'h0000);
    check_val("rng_valid_b", 32'(rd_valid_b), 32'd1);
    check_val("rng_err_b", 32'(addr_err_b), 32'd1);
    op_write(10'd1010, 16'hC3C3, 2'b11);
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b1, 10'(i), 1'b0);
      tick();
    end
    idle();
    drain();
    op_read(10'd1010);
    check_val("rng_wr_a", 32'(dout_a), 32'hC3C3);
    check_val("rng_wr_err_b", 32'(addr_err_b), 32'd1);

    // Block select low: ports idle
    drive(1'b0, 1'b1, 2'b11, 10'd5, 16'h0000, 1'b1, 10'd5, 1'b0);
    tick();
    idle();
    drain();
    check_val("blk0_valid_a", 32'(rd_valid_a), 32'd0);
    op_read(10'd5);
    check_val("blk0_keep_a", 32'(dout_a), 32'hA1FF);

    // Re-init with a read in the init_start cycle and ignored ops during INIT
    for (int i = 0; i < 4; i++) op_write(10'(i), 16'h5555, 2'b11);
    drive(1'b1, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b1, 10'd3, 1'b1);
    tick();
    run_init(1'b1, n_a, n_b);
    check_val("reinit_len_a", 32'(n_a), 32'd1024);
    check_val("reinit_len_b", 32'(n_b), 32'd1000);
    for (int i = 0; i < 4; i++) begin
      op_read(10'(i));
      check_val($sformatf("reinit_rd%0d_a", i), 32'(dout_a), 32'h0000);
    end

    // Reset in the middle of the sweep
    drive(1'b0, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b0, 10'd0, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 2000 && cnt_m[0] != 300; i++) tick();
    rst = 1'b0;
    #1;
    model_reset();
    compare_dut(0);
    compare_dut(1);
    tick();
    tick();
    rst = 1'b1;
    run_init(1'b0, n_a, n_b);
    check_val("midrst_len_a", 32'(n_a), 32'd1024);

    // Read latency
    op_write(10'd2, 16'hBEEF, 2'b11);
    drive(1'b1, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b1, 10'd2, 1'b0);
    tick();
    idle();
    n = 1;
    while (!rd_valid_a && n < 5) begin
      tick();
      n++;
    end
    check_val("latency_a", 32'(n), 32'(LAT));
    check_val("latency_dout_a", 32'(dout_a), 32'hBEEF);
    drain();

    check_val("sb_empty_a", 32'(q_a.size()), 32'd0);
    check_val("sb_empty_b", 32'(q_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
